// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: opcodes, FSM states,
// pixel colour width and small arithmetic helpers.
package uart_cmd_pkg;

  localparam int RGB_WIDTH = 24;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_PIXEL  = 8'h50;  // 'P'
  localparam logic [7:0] OP_BRIGHT = 8'h42;  // 'B'
  localparam logic [7:0] OP_SWAP   = 8'h53;  // 'S'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P_ROW,
    ST_P_COL,
    ST_P_R,
    ST_P_G,
    ST_P_B,
    ST_B_VAL
  } state_e;

  // True when an address byte is representable in 'width' bits.
  function automatic logic fits(input logic [7:0] value, input int width);
    return (value >> width) == 8'd0;
  endfunction

  // Error counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Receiver-to-decoder byte interface: the receiver drives (master), the
// decoder observes (slave).
interface uart_cmd_decoder_if #(
  parameter int DATA_COUNT = 8
);
  logic [DATA_COUNT-1:0] rx_data;
  logic                  rx_running;
  logic                  rx_invalid;

  modport master (output rx_data, output rx_running, output rx_invalid);
  modport slave  (input  rx_data, input  rx_running, input  rx_invalid);
endinterface

// File: rtl/uart_byte_capture.sv
// Counts the receiver's shift edges to detect frame completion and presents
// the finished byte for one cycle at the following edge (the commit edge).
// The receiver's clock is gated, so the commit edge is normally the first
// edge of the next frame; rx_data still holds the completed byte there
// because the receiver only updates it after that edge.
module uart_byte_capture #(
  parameter int DATA_COUNT = 8,
  parameter int STOP_COUNT = 1
) (
  input  logic                  reset,
  input  logic                  clk_baudrate,
  input  logic [DATA_COUNT-1:0] rx_data,
  input  logic                  rx_running,
  input  logic                  rx_invalid,
  output logic                  byte_valid,
  output logic [DATA_COUNT-1:0] byte_data,
  output logic                  byte_invalid
);

  localparam int FRAME_EDGES = DATA_COUNT + STOP_COUNT;
  localparam int CNT_W       = $clog2(FRAME_EDGES + 1);

  logic [CNT_W-1:0] edge_cnt;
  logic             pending;
  logic             frame_done;

  assign frame_done = rx_running && (edge_cnt == CNT_W'(FRAME_EDGES - 1));

  // Edge counter and pending flag. A pending byte always commits on the very
  // next edge, so pending simply follows frame_done; if a new frame finishes
  // on a commit edge, the commit happens now and the new byte stays pending.
  always_ff @(posedge clk_baudrate or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop in the
    // design samples pre-edge values regardless of statement order.
    if (reset) begin
      edge_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      if (!rx_running || frame_done) edge_cnt <= '0;
      else                           edge_cnt <= edge_cnt + 1'b1;
      pending <= frame_done;
    end
  end

  // The decoder samples these at the commit edge, i.e. the pre-update value.
  assign byte_valid   = pending;
  assign byte_data    = rx_data;
  assign byte_invalid = rx_invalid;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses committed UART bytes into LED-matrix framebuffer commands:
// pixel write (P row col r g b), brightness (B val) and buffer swap (S).
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int         DATA_COUNT   = 8,
  parameter int         STOP_COUNT   = 1,
  parameter int         ROW_WIDTH    = 5,
  parameter int         COL_WIDTH    = 5,
  parameter logic [7:0] BRIGHT_RESET = 8'hFF
) (
  input  logic                          reset,
  input  logic                          clk_baudrate,
  uart_cmd_decoder_if.slave             rx,
  output logic [ROW_WIDTH+COL_WIDTH-1:0] pixel_addr,
  output logic [RGB_WIDTH-1:0]          pixel_rgb,
  output logic                          pixel_we,
  output logic [7:0]                    brightness,
  output logic                          swap,
  output logic [7:0]                    error_count,
  output logic                          busy
);

  logic                  byte_valid;
  logic [DATA_COUNT-1:0] byte_data;
  logic                  byte_invalid;
  logic [7:0]            cmd_byte;

  state_e                state;
  logic [ROW_WIDTH-1:0]  row_q;
  logic [COL_WIDTH-1:0]  col_q;
  logic [7:0]            r_q;
  logic [7:0]            g_q;
  logic                  addr_bad;

  uart_byte_capture #(
    .DATA_COUNT (DATA_COUNT),
    .STOP_COUNT (STOP_COUNT)
  ) u_capture (
    .reset        (reset),
    .clk_baudrate (clk_baudrate),
    .rx_data      (rx.rx_data),
    .rx_running   (rx.rx_running),
    .rx_invalid   (rx.rx_invalid),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_invalid (byte_invalid)
  );

  assign cmd_byte = 8'(byte_data);

  // Command FSM: one step per committed byte; strobes last one cycle.
  // busy is kept as its own flop, set/cleared on every IDLE entry/exit.
  always_ff @(posedge clk_baudrate or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      r_q         <= '0;
      g_q         <= '0;
      addr_bad    <= 1'b0;
      pixel_addr  <= '0;
      pixel_rgb   <= '0;
      pixel_we    <= 1'b0;
      brightness  <= BRIGHT_RESET;
      swap        <= 1'b0;
      error_count <= '0;
      busy        <= 1'b0;
    end else begin
      pixel_we <= 1'b0;
      swap     <= 1'b0;
      if (byte_valid) begin
        if (byte_invalid) begin
          // Break aborts any partial command; only a real abort is an error.
          if (state != ST_IDLE) error_count <= sat_inc(error_count);
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          case (state)
            ST_IDLE: begin
              case (cmd_byte)
                OP_NOP: ;
                OP_PIXEL: begin
                  state <= ST_P_ROW;
                  busy  <= 1'b1;
                end
                OP_BRIGHT: begin
                  state <= ST_B_VAL;
                  busy  <= 1'b1;
                end
                OP_SWAP: swap <= 1'b1;
                default: error_count <= sat_inc(error_count);
              endcase
            end
            ST_P_ROW: begin
              row_q    <= cmd_byte[ROW_WIDTH-1:0];
              addr_bad <= !fits(cmd_byte, ROW_WIDTH);
              state    <= ST_P_COL;
            end
            ST_P_COL: begin
              col_q <= cmd_byte[COL_WIDTH-1:0];
              if (!fits(cmd_byte, COL_WIDTH)) addr_bad <= 1'b1;
              state <= ST_P_R;
            end
            ST_P_R: begin
              r_q   <= cmd_byte;
              state <= ST_P_G;
            end
            ST_P_G: begin
              g_q   <= cmd_byte;
              state <= ST_P_B;
            end
            ST_P_B: begin
              if (addr_bad) begin
                error_count <= sat_inc(error_count);
              end else begin
                pixel_we   <= 1'b1;
                pixel_addr <= {row_q, col_q};
                pixel_rgb  <= {r_q, g_q, cmd_byte};
              end
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
            ST_B_VAL: begin
              brightness <= cmd_byte;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end
            default: begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed protocol cases plus
// randomized command streams, checked through an event scoreboard.
module tb_uart_cmd_decoder;
  import uart_cmd_pkg::*;

  localparam int DATA_COUNT = 8;
  localparam int STOP_COUNT = 1;
  localparam int ROW_WIDTH  = 5;
  localparam int COL_WIDTH  = 5;

  typedef enum logic [1:0] {EV_PIXEL, EV_BRIGHT, EV_SWAP} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [9:0]  addr;
    logic [23:0] rgb;
    logic [7:0]  bright;
  } ev_t;

  logic        clk_baudrate = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  pixel_addr;
  logic [23:0] pixel_rgb;
  logic        pixel_we;
  logic [7:0]  brightness;
  logic        swap;
  logic [7:0]  error_count;
  logic        busy;

  uart_cmd_decoder_if #(.DATA_COUNT(DATA_COUNT)) rx_bus ();

  uart_cmd_decoder #(
    .DATA_COUNT   (DATA_COUNT),
    .STOP_COUNT   (STOP_COUNT),
    .ROW_WIDTH    (ROW_WIDTH),
    .COL_WIDTH    (COL_WIDTH),
    .BRIGHT_RESET (8'hFF)
  ) dut (
    .reset        (reset),
    .clk_baudrate (clk_baudrate),
    .rx           (rx_bus),
    .pixel_addr   (pixel_addr),
    .pixel_rgb    (pixel_rgb),
    .pixel_we     (pixel_we),
    .brightness   (brightness),
    .swap         (swap),
    .error_count  (error_count),
    .busy         (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  ev_t exp_q[$];
  logic [7:0] cmd_b[$];
  bit         cmd_inv[$];
  bit         cmd_busy[$];

  int         model_err = 0;
  logic [7:0] model_bright = 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor: pops the scoreboard on every DUT event -------
  task automatic take(input ev_kind_e kind, output ev_t ev, output bit ok);
    ok = 1'b0;
    ev = '0;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL spurious_%s: DUT event, scoreboard empty (t=%0t)", kind.name(), $time);
    end else begin
      ev = exp_q.pop_front();
      if (ev.kind != kind) begin
        miscompares++;
        $display("FAIL event_order: got %s, required %s (t=%0t)", kind.name(), ev.kind.name(), $time);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  logic [7:0] seen_bright = 8'hFF;

  // Sample outputs on the falling edge, half a period after they update.
  always @(negedge clk_baudrate) begin
    ev_t ev;
    bit  ok;
    if (pixel_we) begin
      take(EV_PIXEL, ev, ok);
      if (ok) begin
        check("pixel_addr", 32'(pixel_addr), 32'(ev.addr));
        check("pixel_rgb", 32'(pixel_rgb), 32'(ev.rgb));
      end
    end
    if (swap) take(EV_SWAP, ev, ok);
    if (brightness !== seen_bright) begin
      take(EV_BRIGHT, ev, ok);
      if (ok) check("brightness", 32'(brightness), 32'(ev.bright));
      seen_bright = brightness;
    end
  end

  // ---------------- stimulus: receiver frame model -------------------------
  task automatic pulse();
    #5 clk_baudrate = 1'b1;
    #5 clk_baudrate = 1'b0;
  endtask

  // One frame: a start edge (commits the previous byte, still on rx_data),
  // then DATA+STOP shift edges; the receiver's register reaches the new byte
  // after the last shift edge, and the clock then stops.
  task automatic send_frame(input logic [7:0] value, input bit invalid);
    rx_bus.rx_running = 1'b0;
    pulse();
    rx_bus.rx_running = 1'b1;
    for (int i = 0; i < DATA_COUNT + STOP_COUNT; i++) begin
      pulse();
      rx_bus.rx_data    = 8'($urandom);
      rx_bus.rx_invalid = 1'b0;
    end
    rx_bus.rx_data    = value;
    rx_bus.rx_invalid = invalid;
    rx_bus.rx_running = 1'b0;
  endtask

  task automatic stage(input logic [7:0] b, input bit inv, input bit bsy);
    cmd_b.push_back(b);
    cmd_inv.push_back(inv);
    cmd_busy.push_back(bsy);
  endtask

  // Byte k commits at the start of frame k+1; busy after each commit comes
  // from the staged table. A trailing NOP pad commits the final byte.
  task automatic run_cmd();
    int n;
    n = cmd_b.size();
    for (int k = 0; k < n; k++) begin
      send_frame(cmd_b[k], cmd_inv[k]);
      if (k > 0) check("busy_mid_cmd", 32'(busy), 32'(cmd_busy[k-1]));
    end
    send_frame(OP_NOP, 1'b0);
    check("busy_after_cmd", 32'(busy), 32'(cmd_busy[n-1]));
    check("error_count", 32'(error_count), 32'((model_err > 255) ? 255 : model_err));
    cmd_b.delete();
    cmd_inv.delete();
    cmd_busy.delete();
  endtask

  // ---------------- reference model: one task per command ------------------
  task automatic cmd_pixel(input int row, input int col, input int r, input int g, input int b);
    ev_t ev;
    stage(OP_PIXEL, 0, 1);
    stage(8'(row), 0, 1);
    stage(8'(col), 0, 1);
    stage(8'(r), 0, 1);
    stage(8'(g), 0, 1);
    stage(8'(b), 0, 0);
    if (row < 32 && col < 32) begin
      ev = '0;
      ev.kind = EV_PIXEL;
      ev.addr = 10'(row * 32 + col);
      ev.rgb  = 24'(r * 65536 + g * 256 + b);
      exp_q.push_back(ev);
    end else begin
      model_err++;
    end
    run_cmd();
  endtask

  task automatic cmd_bright(input logic [7:0] v);
    ev_t ev;
    stage(OP_BRIGHT, 0, 1);
    stage(v, 0, 0);
    if (v != model_bright) begin
      ev = '0;
      ev.kind = EV_BRIGHT;
      ev.bright = v;
      exp_q.push_back(ev);
    end
    model_bright = v;
    run_cmd();
  endtask

  task automatic cmd_swap();
    ev_t ev;
    stage(OP_SWAP, 0, 0);
    ev = '0;
    ev.kind = EV_SWAP;
    exp_q.push_back(ev);
    run_cmd();
  endtask

  task automatic cmd_single(input logic [7:0] op, input bit inv, input bit is_error);
    stage(op, inv, 0);
    if (is_error) model_err++;
    run_cmd();
  endtask

  // Opcode plus nargs argument bytes, then a break frame.
  task automatic cmd_abort(input logic [7:0] op, input int nargs, input logic [7:0] first_arg);
    stage(op, 0, 1);
    for (int i = 0; i < nargs; i++) stage((i == 0) ? first_arg : 8'($urandom), 0, 1);
    stage(8'h00, 1, 0);
    model_err++;
    run_cmd();
  endtask

  function automatic logic [7:0] bad_opcode();
    logic [7:0] op;
    do op = 8'($urandom);
    while (op == OP_NOP || op == OP_PIXEL || op == OP_BRIGHT || op == OP_SWAP);
    return op;
  endfunction

  task automatic random_cmd();
    int sel;
    int row;
    int col;
    sel = $urandom_range(0, 9);
    row = ($urandom_range(0, 4) == 0) ? $urandom_range(32, 255) : $urandom_range(0, 31);
    col = ($urandom_range(0, 4) == 0) ? $urandom_range(32, 255) : $urandom_range(0, 31);
    case (sel)
      0, 1, 2: cmd_pixel(row, col, $urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 255));
      3: cmd_bright(8'($urandom));
      4: cmd_swap();
      5: cmd_single(OP_NOP, 0, 0);
      6: cmd_single(bad_opcode(), 0, 1);
      7: cmd_abort(OP_PIXEL, $urandom_range(1, 4), 8'($urandom));
      8: cmd_abort(OP_BRIGHT, 0, 8'h00);
      default: cmd_single(8'h00, 1, 0);  // break while idle: no error
    endcase
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pixel_addr"}, 32'(pixel_addr), 32'h0);
    check({tag, "_pixel_rgb"}, 32'(pixel_rgb), 32'h0);
    check({tag, "_pixel_we"}, 32'(pixel_we), 32'h0);
    check({tag, "_brightness"}, 32'(brightness), 32'hFF);
    check({tag, "_swap"}, 32'(swap), 32'h0);
    check({tag, "_error_count"}, 32'(error_count), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic apply_reset();
    ev_t ev;
    if (model_bright != 8'hFF) begin
      ev = '0;
      ev.kind = EV_BRIGHT;
      ev.bright = 8'hFF;
      exp_q.push_back(ev);
    end
    model_bright = 8'hFF;
    model_err = 0;
    #2 reset = 1'b1;
    #3 check_reset_values("reset");
    #2 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx_bus.rx_data    = '0;
    rx_bus.rx_running = 1'b0;
    rx_bus.rx_invalid = 1'b0;
    apply_reset();

    // Directed protocol cases.
    cmd_pixel(3, 7, 'h10, 'h20, 'h30);
    cmd_bright(8'h40);
    cmd_swap();
    cmd_single(8'h7E, 0, 1);
    cmd_pixel(40, 1, 1, 1, 1);
    cmd_abort(OP_PIXEL, 1, 8'd3);
    cmd_swap();

    repeat (120) random_cmd();

    // Reset in the middle of a pixel command with a byte still pending.
    send_frame(OP_PIXEL, 1'b0);
    send_frame(8'd4, 1'b0);
    send_frame(8'd9, 1'b0);
    apply_reset();

    repeat (60) random_cmd();

    // Saturation: 300 unknown opcodes in a row.
    for (int i = 0; i < 300; i++) begin
      stage(bad_opcode(), 0, 0);
      model_err++;
    end
    run_cmd();
    cmd_swap();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
